// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: turns the hps_io ioctl byte stream into SDRAM port writes
// over a toggle req/ack handshake. ROM bytes are optionally paired into 16-bit
// words, DIP bytes are captured locally, and strobes that arrive while stalled
// are flagged as overrun.
module ioctl_rom_loader #(
  parameter bit          PACK16    = 1'b1,
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [7:0]  DIP_INDEX = 8'd254,
  parameter int          DIP_BYTES = 8,
  parameter logic [24:0] ROM_BYTES = 25'h1000000,
  parameter logic [23:0] SDR_BASE  = 24'h0
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [23:0]            sdr_addr,
  output logic [15:0]            sdr_din,
  output logic                   sdr_wrl,
  output logic                   sdr_wrh,
  output logic                   sdr_req,
  input  logic                   sdr_ack,
  output logic [8*DIP_BYTES-1:0] dip_sw,
  output logic [24:0]            rom_bytes,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WRITE, S_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             hold_data_q, hold_data_d;
  logic [23:0]            hold_waddr_q, hold_waddr_d;
  logic                   ret_hold_q, ret_hold_d;   // return to HOLD when the write completes
  logic                   pend_q, pend_d;           // held byte still needs a high-lane write
  logic [23:0]            sdr_addr_q, sdr_addr_d;
  logic [15:0]            sdr_din_q, sdr_din_d;
  logic                   sdr_wrl_q, sdr_wrl_d;
  logic                   sdr_wrh_q, sdr_wrh_d;
  logic                   sdr_req_q, sdr_req_d;
  logic                   dl_q, dl_d;
  logic                   overrun_q, overrun_d;
  logic [24:0]            rom_bytes_q, rom_bytes_d;
  logic [8*DIP_BYTES-1:0] dip_q, dip_d;

  logic        outstanding;
  logic        wait_c;
  logic        dl_rise;
  logic        rom_acc;
  logic        dip_acc;
  logic        byte_odd;
  logic [23:0] byte_waddr;

  // Issue request computed by the FSM and consumed by the SDRAM port registers.
  logic        issue;
  logic [23:0] iss_waddr;
  logic [15:0] iss_din;
  logic        iss_wrl;
  logic        iss_wrh;

  // Stall while a write is in flight or a second write is queued behind it.
  assign outstanding = (sdr_req_q != sdr_ack);
  assign wait_c      = ((state_q == S_WRITE) || (state_q == S_FLUSH)) && (outstanding || pend_q);
  assign dl_rise     = ioctl_download && !dl_q;
  assign rom_acc     = ioctl_wr && (ioctl_index == ROM_INDEX) && (ioctl_addr < ROM_BYTES) && !wait_c;
  assign dip_acc     = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr < 25'(DIP_BYTES));
  assign byte_odd    = ioctl_addr[0];
  assign byte_waddr  = ioctl_addr[24:1];

  assign ioctl_wait = wait_c;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_din    = sdr_din_q;
  assign sdr_wrl    = sdr_wrl_q;
  assign sdr_wrh    = sdr_wrh_q;
  assign sdr_req    = sdr_req_q;
  assign dip_sw     = dip_q;
  assign rom_bytes  = rom_bytes_q;
  assign overrun    = overrun_q;
  assign busy       = (ioctl_download && (ioctl_index == ROM_INDEX)) || (state_q != S_IDLE);

  // Next-state logic; a write that completes this cycle hands over to IDLE/HOLD
  // immediately so a byte strobed in the same cycle is handled without a gap.
  always_comb begin
    logic eff_idle;
    logic eff_hold;
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_waddr_d = hold_waddr_q;
    ret_hold_d   = ret_hold_q;
    pend_d       = pend_q;
    issue        = 1'b0;
    iss_waddr    = hold_waddr_q;
    iss_din      = {hold_data_q, hold_data_q};
    iss_wrl      = 1'b1;
    iss_wrh      = 1'b0;
    eff_idle     = 1'b0;
    eff_hold     = 1'b0;

    case (state_q)
      S_IDLE:  eff_idle = 1'b1;
      S_HOLD:  eff_hold = 1'b1;
      S_WRITE: begin
        if (!outstanding) begin
          if (pend_q) begin
            issue   = 1'b1;
            iss_wrl = 1'b0;
            iss_wrh = 1'b1;
            pend_d  = 1'b0;
          end else if (ret_hold_q) begin
            eff_hold = 1'b1;
          end else begin
            eff_idle = 1'b1;
          end
        end
      end
      S_FLUSH: if (!outstanding) eff_idle = 1'b1;
      default: eff_idle = 1'b1;
    endcase

    if (eff_idle || eff_hold) begin
      state_d    = eff_hold ? S_HOLD : S_IDLE;
      ret_hold_d = 1'b0;
      if (!PACK16) begin
        if (rom_acc) begin
          issue     = 1'b1;
          iss_waddr = byte_waddr;
          iss_din   = {ioctl_dout, ioctl_dout};
          iss_wrl   = !byte_odd;
          iss_wrh   = byte_odd;
          state_d   = S_WRITE;
        end
      end else if (eff_idle) begin
        if (rom_acc && !byte_odd) begin
          hold_data_d  = ioctl_dout;
          hold_waddr_d = byte_waddr;
          state_d      = S_HOLD;
        end else if (rom_acc) begin
          issue     = 1'b1;
          iss_waddr = byte_waddr;
          iss_din   = {ioctl_dout, ioctl_dout};
          iss_wrl   = 1'b0;
          iss_wrh   = 1'b1;
          state_d   = S_WRITE;
        end
      end else begin
        if (rom_acc && byte_odd && (byte_waddr == hold_waddr_q)) begin
          issue   = 1'b1;
          iss_din = {ioctl_dout, hold_data_q};
          iss_wrh = 1'b1;
          state_d = S_WRITE;
        end else if (rom_acc && byte_odd) begin
          // flush the held low byte now, the odd byte follows as a high-lane write
          issue        = 1'b1;
          hold_data_d  = ioctl_dout;
          hold_waddr_d = byte_waddr;
          pend_d       = 1'b1;
          state_d      = S_WRITE;
        end else if (rom_acc) begin
          issue        = 1'b1;
          hold_data_d  = ioctl_dout;
          hold_waddr_d = byte_waddr;
          ret_hold_d   = 1'b1;
          state_d      = S_WRITE;
        end else if (!ioctl_download) begin
          issue   = 1'b1;
          state_d = S_FLUSH;
        end
      end
    end
  end

  // SDRAM port registers: loaded and req toggled together, held until ack matches.
  always_comb begin
    sdr_addr_d = sdr_addr_q;
    sdr_din_d  = sdr_din_q;
    sdr_wrl_d  = sdr_wrl_q;
    sdr_wrh_d  = sdr_wrh_q;
    sdr_req_d  = sdr_req_q;
    if (issue) begin
      sdr_addr_d = iss_waddr + SDR_BASE;
      sdr_din_d  = iss_din;
      sdr_wrl_d  = iss_wrl;
      sdr_wrh_d  = iss_wrh;
      sdr_req_d  = !sdr_req_q;
    end
  end

  // Download bookkeeping: byte counter, overrun flag and DIP capture.
  always_comb begin
    logic [24:0] cnt_base;
    dl_d        = ioctl_download;
    cnt_base    = dl_rise ? 25'd0 : rom_bytes_q;
    rom_bytes_d = cnt_base;
    if (rom_acc && (cnt_base != 25'h1FFFFFF)) rom_bytes_d = cnt_base + 25'd1;
    overrun_d = dl_rise ? 1'b0 : overrun_q;
    if (ioctl_wr && wait_c) overrun_d = 1'b1;
    dip_d = dip_q;
    if (dip_acc) begin
      for (int i = 0; i < DIP_BYTES; i++) begin
        if (ioctl_addr[3:0] == 4'(i)) dip_d[8*i +: 8] = ioctl_dout;
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      hold_data_q  <= 8'd0;
      hold_waddr_q <= 24'd0;
      ret_hold_q   <= 1'b0;
      pend_q       <= 1'b0;
      sdr_addr_q   <= 24'd0;
      sdr_din_q    <= 16'd0;
      sdr_wrl_q    <= 1'b0;
      sdr_wrh_q    <= 1'b0;
      sdr_req_q    <= 1'b0;
      dl_q         <= 1'b0;
      overrun_q    <= 1'b0;
      rom_bytes_q  <= 25'd0;
      dip_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_waddr_q <= hold_waddr_d;
      ret_hold_q   <= ret_hold_d;
      pend_q       <= pend_d;
      sdr_addr_q   <= sdr_addr_d;
      sdr_din_q    <= sdr_din_d;
      sdr_wrl_q    <= sdr_wrl_d;
      sdr_wrh_q    <= sdr_wrh_d;
      sdr_req_q    <= sdr_req_d;
      dl_q         <= dl_d;
      overrun_q    <= overrun_d;
      rom_bytes_q  <= rom_bytes_d;
      dip_q        <= dip_d;
    end
  end

endmodule
